// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates and line/frame lengths from active-low h/v sync plus RGB, and locks to the configured mode.
// Latency: one pixel clock from sampled inputs to every output; all outputs for a sample are mutually aligned.
// Backpressure: none, because the video stream is free-running; loss of timing shows up as a timing_error pulse and locked falling.
module vga_timing_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        pixel_valid,
    output logic [7:0]  pixel_red,
    output logic [7:0]  pixel_green,
    output logic [7:0]  pixel_blue,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas
);

    localparam int H_FIRST = H_SYNC + H_BACK;
    localparam int H_LAST  = H_FIRST + H_ACTIVE - 1;
    localparam int V_FIRST = V_SYNC + V_BACK;
    localparam int V_LAST  = V_FIRST + V_ACTIVE - 1;
    localparam logic [10:0] POS_MAX = 11'd2047;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  good_cnt, good_cnt_nxt;
    logic        lose;

    logic        h_sync_q, v_sync_q;
    logic [10:0] h_pos, v_line;
    logic        h_seen, v_seen, v_pending, frame_bad;

    logic        h_fall, v_fall, frame_evt;
    logic [10:0] h_nxt, v_nxt;
    logic [11:0] h_len, v_len;
    logic        h_sat, v_sat;
    logic        line_meas, bad_line, frame_meas, frame_good, in_win;

    // Edge detection, next counter values (index of the sample at this edge) and line/frame quality.
    always_comb begin
        h_fall     = ~h_sync & h_sync_q;
        v_fall     = ~v_sync & v_sync_q;
        frame_evt  = h_fall & (v_pending | v_fall);

        h_nxt = h_pos;
        if (h_fall)
            h_nxt = 11'd0;
        else if (h_pos != POS_MAX)
            h_nxt = h_pos + 11'd1;

        v_nxt = v_line;
        if (frame_evt)
            v_nxt = 11'd0;
        else if (h_fall && (v_line != POS_MAX))
            v_nxt = v_line + 11'd1;

        h_len      = {1'b0, h_pos} + 12'd1;
        v_len      = {1'b0, v_line} + 12'd1;
        h_sat      = (h_nxt == POS_MAX);
        v_sat      = (v_nxt == POS_MAX);
        line_meas  = h_fall & h_seen;
        bad_line   = line_meas & (h_len != 12'(H_TOTAL));
        frame_meas = frame_evt & v_seen;
        // The line closing at this h fall belongs to the frame being judged.
        frame_good = (v_len == 12'(V_TOTAL)) & ~frame_bad & ~bad_line;
        in_win     = (h_nxt >= 11'(H_FIRST)) && (h_nxt <= 11'(H_LAST)) &&
                     (v_nxt >= 11'(V_FIRST)) && (v_nxt <= 11'(V_LAST));
    end

    // Lock FSM: count consecutive good frames while searching, drop out on any timing fault.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        lose         = 1'b0;
        case (state)
            SEARCH: begin
                if (frame_meas) begin
                    if (frame_good) begin
                        if ((good_cnt + 3'd1) == 3'(LOCK_FRAMES)) begin
                            state_nxt    = LOCKED;
                            good_cnt_nxt = 3'd0;
                        end else begin
                            good_cnt_nxt = good_cnt + 3'd1;
                        end
                    end else begin
                        good_cnt_nxt = 3'd0;
                    end
                end
            end
            LOCKED: begin
                if (bad_line || h_sat || v_sat || (frame_meas && !frame_good)) begin
                    state_nxt    = SEARCH;
                    good_cnt_nxt = 3'd0;
                    lose         = 1'b1;
                end
            end
            default: begin
                state_nxt    = SEARCH;
                good_cnt_nxt = 3'd0;
            end
        endcase
    end

    // FSM state and good-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    // Sync history, position counters and the "seen"/pending bookkeeping; sync resets high so a held-low sync is no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync_q  <= 1'b1;
            v_sync_q  <= 1'b1;
            h_pos     <= 11'd0;
            v_line    <= 11'd0;
            h_seen    <= 1'b0;
            v_seen    <= 1'b0;
            v_pending <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            h_sync_q <= h_sync;
            v_sync_q <= v_sync;
            h_pos    <= h_nxt;
            v_line   <= v_nxt;
            if (h_fall)
                h_seen <= 1'b1;
            else if (h_sat)
                h_seen <= 1'b0;
            if (frame_evt)
                v_seen <= 1'b1;
            if (frame_evt)
                v_pending <= 1'b0;
            else if (v_fall)
                v_pending <= 1'b1;
            // Any fault taints the running frame so it cannot count toward lock.
            if (frame_evt)
                frame_bad <= 1'b0;
            else if (bad_line || h_sat || v_sat)
                frame_bad <= 1'b1;
        end
    end

    // Registered outputs: pixel data, pulses, lock status and measurements.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x      <= 11'd0;
            pixel_y      <= 11'd0;
            pixel_valid  <= 1'b0;
            pixel_red    <= 8'd0;
            pixel_green  <= 8'd0;
            pixel_blue   <= 8'd0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
            h_total_meas <= 11'd0;
            v_total_meas <= 11'd0;
        end else begin
            pixel_red    <= red;
            pixel_green  <= green;
            pixel_blue   <= blue;
            pixel_valid  <= in_win && (state_nxt == LOCKED);
            if (in_win) begin
                pixel_x <= h_nxt - 11'(H_FIRST);
                pixel_y <= v_nxt - 11'(V_FIRST);
            end
            line_start   <= h_fall;
            frame_start  <= frame_evt;
            locked       <= (state_nxt == LOCKED);
            timing_error <= lose;
            if (line_meas)
                h_total_meas <= h_len[10:0];
            if (frame_meas)
                v_total_meas <= v_len[10:0];
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder in a reduced 16x10 mode (visible 8x4 at h 4..11, v 3..6).
// Stimulus pushes expected visible pixels into a queue; a negedge monitor pops on every pixel_valid.
// Directed phases: lock, short line, saturation, mid-line reset, short frame.
module tb_vga_timing_decoder;

    localparam int HS = 2, HB = 2, HA = 8, HT = 16;
    localparam int VS = 1, VB = 2, VA = 4, VT = 10;
    localparam int H0 = HS + HB, V0 = VS + VB;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset, h_sync, v_sync;
    logic [7:0]  red, green, blue;
    logic [10:0] pixel_x, pixel_y, h_total_meas, v_total_meas;
    logic        pixel_valid, line_start, frame_start, locked, timing_error;
    logic [7:0]  pixel_red, pixel_green, pixel_blue;

    pix_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   frame_no = 0;
    int   errs;

    always #5 clk = ~clk;

    vga_timing_decoder #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
        .line_start(line_start), .frame_start(frame_start), .locked(locked),
        .timing_error(timing_error), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: every valid pixel must match the head of the expected queue.
    always @(negedge clk) begin
        pix_t got, e;
        if (pixel_valid) begin
            got = '{x: pixel_x, y: pixel_y, r: pixel_red, g: pixel_green, b: pixel_blue};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d, expected no valid pixel", pixel_x, pixel_y);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL pixel: got x=%0d y=%0d rgb=%h/%h/%h expected x=%0d y=%0d rgb=%h/%h/%h",
                             got.x, got.y, got.r, got.g, got.b, e.x, e.y, e.r, e.g, e.b);
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_valid"}, pixel_valid, 0);
        check({tag, "_x"}, pixel_x, 0);
        check({tag, "_y"}, pixel_y, 0);
        check({tag, "_hmeas"}, h_total_meas, 0);
        check({tag, "_vmeas"}, v_total_meas, 0);
        check({tag, "_ls"}, line_start, 0);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_err"}, timing_error, 0);
        check({tag, "_rgb"}, {pixel_red, pixel_green, pixel_blue}, 0);
    endtask

    // One line: index i is driven at a negedge; outputs seen there belong to the previous sample.
    task automatic drive_line(input int len, input int l, input bit push, input int probe);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (probe == 1 && i == 1) begin
                check("err_pulse", timing_error, 1);
                check("lock_drop", locked, 0);
                check("hmeas_short", h_total_meas, 15);
            end
            if (probe == 1 && i == 2) check("err_one_cycle", timing_error, 0);
            if (probe == 2 && i == 2) check("hmeas_unmeasured", h_total_meas, 16);
            if (probe == 3 && i == 1) begin
                check("ls_with_fs", line_start, 1);
                check("fs_with_ls", frame_start, 1);
                check("lock_rise", locked, 1);
            end
            if (probe == 3 && i == 2) begin
                check("fs_one_cycle", frame_start, 0);
                check("ls_one_cycle", line_start, 0);
            end
            h_sync = (i < HS) ? 1'b0 : 1'b1;
            v_sync = (l < VS) ? 1'b0 : 1'b1;
            red    = 8'(i * 7 + l);
            green  = 8'(l * 13 + 1);
            blue   = 8'(frame_no);
            if (push && i >= H0 && i < H0 + HA && l >= V0 && l < V0 + VA)
                exp_q.push_back('{x: 11'(i - H0), y: 11'(l - V0), r: red, g: green, b: blue});
        end
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input int push_max,
                               input int probe_line, input int probe);
        frame_no++;
        for (int l = 0; l < nlines; l++)
            drive_line((l == short_line) ? HT - 1 : HT, l, l <= push_max,
                       (l == probe_line) ? probe : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        red = 8'd0; green = 8'd0; blue = 8'd0;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        reset = 1'b0;

        // Nominal: event 1 unmeasured, event 2 counts, event 3 locks.
        drive_frame(10, -1, -1, -1, 0);
        drive_frame(10, -1, -1, -1, 0);
        check("lock_wait", locked, 0);
        check("hmeas_nom", h_total_meas, 16);
        check("vmeas_nom", v_total_meas, 10);
        drive_frame(10, -1, 9, 0, 3);
        check("locked_c", locked, 1);

        // One 15-cycle line: loss on the next h fall, relock two good frames after the boundary.
        drive_frame(10, 5, 5, 6, 1);
        drive_frame(10, -1, -1, -1, 0);
        check("relock_e", locked, 0);
        drive_frame(10, -1, -1, -1, 0);
        check("relock_f", locked, 0);
        drive_frame(10, -1, 9, -1, 0);
        check("relock_g", locked, 1);

        // h_sync held high: saturation drops lock once; next h fall is unmeasured.
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (timing_error) errs++;
            h_sync = 1'b1; v_sync = 1'b1;
        end
        check("sat_err_pulses", errs, 1);
        check("sat_lock", locked, 0);
        drive_frame(10, -1, -1, 0, 2);
        drive_frame(10, -1, -1, -1, 0);
        drive_frame(10, -1, 9, -1, 0);
        check("relock_j", locked, 1);

        // Mid-line reset while locked.
        drive_frame(3, -1, -1, -1, 0);
        drive_line(4, 3, 1'b0, 0);
        check("prerst_lock", locked, 1);
        @(negedge clk);
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive_frame(10, -1, -1, -1, 0);
        drive_frame(10, -1, -1, -1, 0);
        check("rst_relock_wait", locked, 0);
        drive_frame(10, -1, 9, -1, 0);
        check("rst_relock", locked, 1);

        // Short (9-line) frame after one good frame clears the count.
        do_reset();
        drive_frame(10, -1, -1, -1, 0);
        drive_frame(9, -1, -1, -1, 0);
        drive_frame(10, -1, -1, -1, 0);
        check("vmeas_short", v_total_meas, 9);
        check("short_lock_r", locked, 0);
        drive_frame(10, -1, -1, -1, 0);
        check("short_lock_s", locked, 0);
        drive_frame(10, -1, 9, -1, 0);
        check("short_lock_t", locked, 1);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_decoder.md
# vga_timing_decoder

Receive-side counterpart of the team's VGA sync generator. Samples active-low h_sync/v_sync and 8-bit RGB in the pixel-clock domain, recovers pixel coordinates, and measures line and frame lengths. Locks once the timing matches the configured mode, and flags loss of lock. Sits on the capture/loopback path so generated video can be checked or re-processed in-fabric.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, h_sync pulse width (cycles)
- H_BACK, 48, back porch (cycles)
- H_TOTAL, 800, expected cycles per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, v_sync pulse width (lines)
- V_BACK, 33, back porch (lines)
- V_TOTAL, 525, expected lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
- clk, in, 1, pixel clock; all inputs synchronous to it
- reset, in, 1, reset; synchronous, active-high
- h_sync, in, 1, horizontal sync, active low
- v_sync, in, 1, vertical sync, active low
- red / green / blue, in, 8 each, pixel data
- pixel_x, out, 11, column of the current output pixel
- pixel_y, out, 11, row of the current output pixel
- pixel_valid, out, 1, output pixel is visible and decoder is locked
- pixel_red / pixel_green / pixel_blue, out, 8 each, registered pixel data
- line_start, out, 1, one-cycle pulse on each h_sync falling edge
- frame_start, out, 1, one-cycle pulse when the line counter is zeroed
- locked, out, 1, timing matches the configured mode
- timing_error, out, 1, one-cycle pulse when lock is lost
- h_total_meas, out, 11, length of the last complete line
- v_total_meas, out, 11, length of the last complete frame, in lines

## Operation

- Edge detect: h_sync_q/v_sync_q hold the previous samples. An h fall is h_sync=0 && h_sync_q=1; v fall is defined the same way.
- h_pos (11 b):
  - On an h fall, h_pos <= 0.
  - Otherwise h_pos <= h_pos+1, saturating at 2047.
  - The sample taken at the same edge carries line index h_pos.
- On an h fall with h_seen=1: h_total_meas <= h_pos+1.
  - h_seen is set on the first h fall after reset.
  - h_seen is cleared when h_pos saturates.
- v fall sets v_pending. On an h fall:
  - If v_pending (including a v fall in the same cycle): v_line <= 0, v_pending <= 0, frame_start pulses.
  - If v_seen is also set: v_total_meas <= v_line+1. v_seen is set at the first such event.
  - Otherwise v_line <= v_line+1, saturating at 2047.
- Visible window:
  - h index: H_SYNC+H_BACK .. H_SYNC+H_BACK+H_ACTIVE-1, i.e. 144..783 by default.
  - v line: V_SYNC+V_BACK .. V_SYNC+V_BACK+V_ACTIVE-1, i.e. 35..514.
- Pixel outputs:
  - pixel_x = h index − 144 and pixel_y = v line − 35, both in the visible window.
  - pixel_valid = in window && locked.
  - RGB is registered every cycle regardless of pixel_valid.
  - Outside the window, pixel_x/pixel_y hold their last values.
- Line check: on a measured h fall, the line is bad if h_pos+1 ≠ H_TOTAL.
- Frame check: on a measured frame event, the frame is good if v_line+1 = V_TOTAL and no bad line or saturation occurred since the previous frame event.
- FSM, SEARCH (locked=0):
  - Each good frame increments good_cnt (3 b).
  - A bad frame clears good_cnt.
  - When good_cnt reaches LOCK_FRAMES, go to LOCKED with locked=1. good_cnt then resets.
- FSM, LOCKED (locked=1):
  - Any bad line, bad frame, or h_pos/v_line saturation goes to SEARCH.
  - On that transition: locked=0, a timing_error pulse, good_cnt cleared.
  - The current frame never counts toward relock.

## Timing

- All outputs are registered. A sample presented before edge n appears at the outputs after edge n (1-cycle latency); all outputs for that sample are mutually aligned.
- line_start and frame_start are high for exactly the cycle following the detecting edge. frame_start coincides with a line_start.
- locked rises in the cycle after the LOCK_FRAMES-th good frame event.
- timing_error and the fall of locked happen in the same cycle.
- Reset values: every output 0, FSM=SEARCH. Internal state at reset:
  - h_seen, v_seen, v_pending, good_cnt = 0.
  - h_sync_q and v_sync_q = 1, so sync held low through reset is not taken as an edge.
- Reset mid-frame: the next h fall starts an unmeasured line, and the first frame after reset is unmeasured.
- Lock therefore needs LOCK_FRAMES+1 v_sync pulses after reset.

## Test plan

- Nominal 800×525 stream from the generator, reset released:
  - locked rises after the 3rd frame event.
  - h_total_meas=800 and v_total_meas=525.
  - Exactly 640×480 pixel_valid cycles per frame thereafter.
  - First valid pixel: x=0, y=0 at index 144 of line 35.
  - Last valid pixel: x=639, y=479.
- Locked stream, one line shortened to 799 cycles:
  - timing_error pulses once and locked drops on that h fall.
  - h_total_meas=799.
  - locked returns 2 good frames after the next frame boundary.
- v_sync fall in the same cycle as an h_sync fall: frame_start and line_start assert together, and v_line resets on that line.
- h_sync held high for 3000 cycles while locked:
  - h_pos saturates at 2047.
  - timing_error pulses at saturation and locked drops.
  - The next h fall is not measured (h_total_meas unchanged).
- Reset asserted mid-line while locked: all outputs read 0 the next cycle, and relock needs 3 frame events.
- Frame with 524 lines in SEARCH after 1 good frame: good_cnt clears and locked stays 0 until 2 further good frames.
